// File: rtl/prbs_checker.sv
// PRBS-8 (x^8+x^6+x^5+x^4+1) receive checker: HUNT -> VERIFY -> LOCKED with flywheel and error counting.
// Optional PRBS_CHK_BITCNT_EN adds a saturating count of bits sampled while locked.
module prbs_checker #(
  parameter int SYNC_LEN    = 16,
  parameter int LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_vld,
  input  logic        clr_cnt,
  output logic        locked,
  output logic [1:0]  state,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam logic [1:0] HUNT   = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;

  logic [1:0]  state_reg, state_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [2:0]  fill_reg, fill_next;
  logic [7:0]  match_reg, match_next;
  logic [5:0]  win_reg, win_next;
  logic [6:0]  win_err_reg, win_err_next;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic        err_pulse_reg, err_pulse_next;

  logic        pred;
  logic        mismatch;
  logic [7:0]  shift_din;
  logic [7:0]  match_inc;
  logic [6:0]  win_err_inc;

  assign pred        = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign mismatch    = din ^ pred;
  assign shift_din   = {lfsr_reg[6:0], din};
  assign match_inc   = match_reg + 8'd1;
  assign win_err_inc = win_err_reg + 7'd1;

  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    win_next       = win_reg;
    win_err_next   = win_err_reg;
    err_cnt_next   = err_cnt_reg;
    err_pulse_next = 1'b0;

    if (din_vld) begin
      case (state_reg)
        HUNT: begin
          lfsr_next = shift_din;
          fill_next = fill_reg + 3'd1;
          // fill_reg==7 means this is the 8th bit; an all-zero register can never predict
          if (fill_reg == 3'd7) begin
            fill_next = 3'd0;
            if (shift_din != 8'd0) begin
              state_next = VERIFY;
            end
          end
        end
        VERIFY: begin
          lfsr_next = shift_din;
          if (mismatch) begin
            match_next = 8'd0;
          end else if (match_inc == 8'(SYNC_LEN)) begin
            state_next   = LOCKED;
            match_next   = 8'd0;
            win_next     = 6'd0;
            win_err_next = 7'd0;
          end else begin
            match_next = match_inc;
          end
        end
        LOCKED: begin
          // Flywheel: feed back the prediction so line errors never enter the register
          lfsr_next = {lfsr_reg[6:0], pred};
          win_next  = win_reg + 6'd1;
          if (mismatch) begin
            err_pulse_next = 1'b1;
            if (err_cnt_reg != 16'hFFFF) begin
              err_cnt_next = err_cnt_reg + 16'd1;
            end
          end
          if (mismatch && (win_err_inc == 7'(LOSS_THRESH))) begin
            state_next   = HUNT;
            lfsr_next    = 8'd0;
            fill_next    = 3'd0;
            match_next   = 8'd0;
            win_next     = 6'd0;
            win_err_next = 7'd0;
          end else if (win_reg == 6'd63) begin
            win_err_next = 7'd0;
          end else if (mismatch) begin
            win_err_next = win_err_inc;
          end
        end
        default: begin
          state_next = HUNT;
          lfsr_next  = 8'd0;
          fill_next  = 3'd0;
          match_next = 8'd0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_next = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      lfsr_reg      <= 8'd0;
      fill_reg      <= 3'd0;
      match_reg     <= 8'd0;
      win_reg       <= 6'd0;
      win_err_reg   <= 7'd0;
      err_cnt_reg   <= 16'd0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      win_reg       <= win_next;
      win_err_reg   <= win_err_next;
      err_cnt_reg   <= err_cnt_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  assign state     = state_reg;
  assign locked    = (state_reg == LOCKED);
  assign err_pulse = err_pulse_reg;
  assign err_cnt   = err_cnt_reg;

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_cnt_reg, bit_cnt_next;

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if (din_vld && (state_reg == LOCKED) && (bit_cnt_reg != 32'hFFFF_FFFF)) begin
      bit_cnt_next = bit_cnt_reg + 32'd1;
    end
    if (clr_cnt) begin
      bit_cnt_next = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= 32'd0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign bit_cnt = bit_cnt_reg;
`else
  assign bit_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model queues expected outputs per driven cycle,
// a monitor pops and compares them after each rising edge; scenario tasks add targeted checks.
module tb_prbs_checker;
  localparam int SYNC  = 16;
  localparam int LOSS  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_vld = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  prbs_checker #(.SYNC_LEN(SYNC), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt),
    .locked(locked), .state(state), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        pulse;
    logic [15:0] ecnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // behavioural reference state
  int          m_state = 0;
  logic [7:0]  m_s = 8'd0;
  int          m_fill = 0, m_match = 0, m_win = 0, m_werr = 0;
  logic [15:0] m_err = 16'd0;
  logic [31:0] m_bit = 32'd0;
  logic        m_pulse = 1'b0;
  logic [7:0]  gen = 8'd0;

  task automatic model_step(input logic r, input logic b, input logic v, input logic c);
    logic p;
    m_pulse = 1'b0;
    if (r) begin
      m_state = 0; m_s = 8'd0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_err = 16'd0; m_bit = 32'd0;
    end else begin
      if (v) begin
        p = m_s[7] ^ m_s[5] ^ m_s[4] ^ m_s[3];
        if (m_state == 0) begin
          m_s = {m_s[6:0], b};
          m_fill++;
          if (m_fill == 8) begin
            m_fill = 0;
            if (m_s != 8'd0) m_state = 1;
          end
        end else if (m_state == 1) begin
          m_s = {m_s[6:0], b};
          if (b == p) begin
            m_match++;
            if (m_match == SYNC) begin
              m_state = 2; m_match = 0; m_win = 0; m_werr = 0;
            end
          end else begin
            m_match = 0;
          end
        end else begin
          m_s = {m_s[6:0], p};
          if (m_bit != 32'hFFFF_FFFF) m_bit++;
          if (b != p) begin
            m_pulse = 1'b1;
            if (m_err != 16'hFFFF) m_err++;
            m_werr++;
          end
          if (m_werr == LOSS) begin
            m_state = 0; m_s = 8'd0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
          end else begin
            m_win++;
            if (m_win == 64) begin
              m_win = 0; m_werr = 0;
            end
          end
        end
      end
      if (c) begin
        m_err = 16'd0; m_bit = 32'd0;
      end
    end
  endtask

  // Drive one cycle; the expected post-edge outputs go to the scoreboard
  task automatic drive(input logic r, input logic b, input logic v, input logic c);
    exp_t e;
    @(negedge clk);
    rst = r; din = b; din_vld = v; clr_cnt = c;
    model_step(r, b, v, c);
    e.st = m_state[1:0];
    e.pulse = m_pulse;
    e.ecnt = m_err;
`ifdef PRBS_CHK_BITCNT_EN
    e.bcnt = m_bit;
`else
    e.bcnt = 32'd0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic gen_bit(output logic b);
    b = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
    gen = {gen[6:0], b};
  endtask

  task automatic send_gen(input logic invert);
    logic b;
    gen_bit(b);
    drive(1'b0, b ^ invert, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    gen = 8'hC8;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({state, err_pulse, err_cnt, bit_cnt} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got state=%b pulse=%b err_cnt=%0d bit_cnt=%0d, expected state=%b pulse=%b err_cnt=%0d bit_cnt=%0d",
                 $time, state, err_pulse, err_cnt, bit_cnt, e.st, e.pulse, e.ecnt, e.bcnt);
      end else begin
        $display("cycle t=%0t state=%b pulse=%b err_cnt=%0d bit_cnt=%0d ok", $time, state, err_pulse, err_cnt, bit_cnt);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, locked, err_pulse, err_cnt, bit_cnt} !== 52'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%b locked=%b pulse=%b err_cnt=%0d bit_cnt=%0d, expected all 0",
               state, locked, err_pulse, err_cnt, bit_cnt);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      send_gen(1'b0);
      if (i == 23 || i == 24) begin
        checks++;
        if (locked !== (i == 24)) begin
          errors++;
          $display("FAIL lock_time bit %0d: got locked=%b, expected %b", i, locked, (i == 24));
        end
      end
    end
    checks++;
    if (err_cnt !== 16'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_200: got err_cnt=%0d locked=%b, expected 0 and 1", err_cnt, locked);
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      send_gen(i == 100);
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_error: got pulses=%0d err_cnt=%0d locked=%b, expected 1 1 1", pulses, err_cnt, locked);
    end
  endtask

  task automatic test_loss_relock();
    do_reset();
    for (int i = 1; i <= 40; i++) send_gen(1'b0);
    for (int i = 41; i <= 63; i++) send_gen(i % 3 == 0);
    checks++;
    if (state !== 2'b00 || err_cnt !== 16'd8) begin
      errors++;
      $display("FAIL loss_of_lock: got state=%b err_cnt=%0d, expected 00 and 8", state, err_cnt);
    end
    for (int k = 1; k <= 24; k++) begin
      send_gen(1'b0);
      if (k == 23 || k == 24) begin
        checks++;
        if (locked !== (k == 24)) begin
          errors++;
          $display("FAIL relock bit %0d: got locked=%b, expected %b", k, locked, (k == 24));
        end
      end
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b00 || locked !== 1'b0) begin
      errors++;
      $display("FAIL all_zero: got state=%b locked=%b, expected 00 0", state, locked);
    end
  endtask

  task automatic test_reset_and_clear();
    do_reset();
    for (int i = 0; i < 30; i++) send_gen(1'b0);
    for (int j = 0; j < 5; j++) begin
      send_gen(1'b1);
      send_gen(1'b0);
      send_gen(1'b0);
    end
    checks++;
    if (err_cnt !== 16'd5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL five_errors: got err_cnt=%0d locked=%b, expected 5 1", err_cnt, locked);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({state, locked, err_pulse, err_cnt, bit_cnt} !== 52'd0) begin
      errors++;
      $display("FAIL reset_mid_lock: got state=%b locked=%b pulse=%b err_cnt=%0d bit_cnt=%0d, expected all 0",
               state, locked, err_pulse, err_cnt, bit_cnt);
    end
    do_reset();
    for (int i = 0; i < 30; i++) send_gen(1'b0);
    send_gen(1'b1);
    send_gen(1'b0);
    send_gen(1'b0);
    begin
      logic b;
      gen_bit(b);
      drive(1'b0, ~b, 1'b1, 1'b1);
    end
    checks++;
    if (err_cnt !== 16'd0 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_error: got err_cnt=%0d err_pulse=%b, expected 0 1", err_cnt, err_pulse);
    end
  endtask

  task automatic test_bitcnt();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < 24; i++) send_gen(1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_gen(1'b0);
      else drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
`ifdef PRBS_CHK_BITCNT_EN
    want = 32'd20;
`else
    want = 32'd0;
`endif
    checks++;
    if (bit_cnt !== want || locked !== 1'b1) begin
      errors++;
      $display("FAIL bit_cnt: got bit_cnt=%0d locked=%b, expected %0d 1", bit_cnt, locked, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_relock();
    test_all_zero();
    test_reset_and_clear();
    test_bitcnt();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter SYNC_LEN, default 16, number of consecutive correct predictions required to declare lock (range 1..255).
REQ-002 Parameter LOSS_THRESH, default 8, number of errors within one 64-bit window that drops lock (range 1..64).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  1  received serial bit, MSB-first stream from an 8-bit LFSR generator.
REQ-006 din_vld  input  1  din is sampled only when din_vld=1; otherwise all state holds.
REQ-007 clr_cnt  input  1  synchronous clear of err_cnt (and bit_cnt when present).
REQ-008 locked  output  1  high while in LOCKED state.
REQ-009 state  output  2  current FSM state: 00 HUNT, 01 VERIFY, 10 LOCKED.
REQ-010 err_pulse  output  1  one-cycle strobe on each mismatch detected in LOCKED.
REQ-011 err_cnt  output  16  saturating count of mismatches detected in LOCKED.

Function
REQ-012 Polynomial x^8+x^6+x^5+x^4+1: predicted bit p = s[7]^s[5]^s[4]^s[3]; register update s <= {s[6:0], b}.
REQ-013 HUNT: each valid bit is shifted in (b=din); a 3-bit fill counter counts to 8; at 8 filled, go to VERIFY if s!=0, else stay in HUNT with the fill counter restarted.
REQ-014 VERIFY: each valid bit, compare din with p; b=din (self-synchronising); match increments the match counter; mismatch clears it and stays in VERIFY.
REQ-015 VERIFY -> LOCKED on the valid bit that brings the match counter to SYNC_LEN; locked rises the following cycle.
REQ-016 LOCKED: b=p (flywheel; received errors do not corrupt s); mismatch asserts err_pulse in the next cycle and increments err_cnt, saturating at 16'hFFFF.
REQ-017 LOCKED loss: a 6-bit window counter counts valid bits; window errors count mismatches; when window errors reach LOSS_THRESH, go to HUNT (fill counter, match counter and s cleared); at window wrap (64 bits) window errors clear.
REQ-018 Mismatches in HUNT/VERIFY never touch err_cnt or err_pulse.
REQ-019 clr_cnt coinciding with a LOCKED mismatch: clear wins, err_cnt=0, err_pulse still asserted.
REQ-020 din_vld=0: no counter, register or state change; err_pulse=0.
REQ-021 Latency: err_pulse and err_cnt update exactly one clk after the sampled erroneous bit.

Reset
REQ-022 rst=1 at any clock edge, including mid-lock: state=HUNT, s=0, all internal counters=0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
REQ-023 rst has priority over clr_cnt and din_vld.

Configuration
REQ-024 Macro PRBS_CHK_BITCNT_EN defined: 32-bit output bit_cnt counts valid bits sampled in LOCKED, saturating at 32'hFFFFFFFF, cleared by rst or clr_cnt.
REQ-025 Macro PRBS_CHK_BITCNT_EN undefined: bit_cnt port present, tied to 0, no counter logic.

Verification
REQ-026 Generator seeded 8'hC8, clean stream, SYNC_LEN=16 -> locked rises after bit 8+16=24, err_cnt stays 0 over 200 bits.
REQ-027 Locked, single bit inverted at stream bit 100 -> exactly one err_pulse, err_cnt=1, locked stays 1, following bits produce no further errors.
REQ-028 Locked, 8 inverted bits within one 64-bit window, LOSS_THRESH=8 -> state=00 the cycle after the 8th error, relock after 24 further clean bits.
REQ-029 All-zero stream -> state stays HUNT indefinitely, locked=0.
REQ-030 rst pulsed while locked with err_cnt=5 -> next cycle all outputs 0, state=HUNT; clr_cnt on same cycle as an error -> err_cnt=0, err_pulse=1.
REQ-031 PRBS_CHK_BITCNT_EN defined, din_vld toggled 50% during 40 locked cycles -> bit_cnt=20; undefined -> bit_cnt=0.
